// File: rtl/game_report_tx.sv
// Game status reporter: snapshots game inputs on change and streams a fixed
// 16-byte ASCII line ("Sx Tdddd Fhhhh\r\n") to a byte-wide UART transmitter.
module game_report_tx #(
    parameter int unsigned MIN_GAP = 0
) (
    input  logic        clk_cnt,
    input  logic        rst_n,
    input  logic [1:0]  game_state,
    input  logic [15:0] card_find,
    input  logic [11:0] left_time,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  msg_cnt
);

    localparam int unsigned GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int unsigned GAP_LAST = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_SEND, S_GAP} state_t;

    state_t             state, state_nxt;
    logic               first_flag;
    logic [1:0]         snap_gs;
    logic [15:0]        snap_cf;
    logic [11:0]        snap_lt;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;
    logic [11:0]        conv_bin;
    logic [3:0]         conv_cnt;
    logic [3:0]         byte_idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic [7:0]         msg_byte;
    logic               start;
    logic               xfer;
    logic               last_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign start     = first_flag ||
                       ({game_state, card_find, left_time} != {snap_gs, snap_cf, snap_lt});
    assign tx_valid  = (state == S_SEND);
    assign busy      = (state != S_IDLE);
    assign xfer      = tx_valid && tx_ready;
    assign last_byte = (byte_idx == 4'd15);
    assign tx_data   = tx_valid ? msg_byte : 8'h00;

    // Double-dabble: any BCD digit >= 5 gets +3 before the next left shift.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns msg_byte and no latch is inferred.
        msg_byte = 8'h00;
        case (byte_idx)
            4'd0:    msg_byte = 8'h53;
            4'd1:    msg_byte = {6'b001100, snap_gs};
            4'd2:    msg_byte = 8'h20;
            4'd3:    msg_byte = 8'h54;
            4'd4:    msg_byte = {4'h3, bcd[15:12]};
            4'd5:    msg_byte = {4'h3, bcd[11:8]};
            4'd6:    msg_byte = {4'h3, bcd[7:4]};
            4'd7:    msg_byte = {4'h3, bcd[3:0]};
            4'd8:    msg_byte = 8'h20;
            4'd9:    msg_byte = 8'h46;
            4'd10:   msg_byte = hex_ascii(snap_cf[15:12]);
            4'd11:   msg_byte = hex_ascii(snap_cf[11:8]);
            4'd12:   msg_byte = hex_ascii(snap_cf[7:4]);
            4'd13:   msg_byte = hex_ascii(snap_cf[3:0]);
            4'd14:   msg_byte = 8'h0D;
            default: msg_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_CONV;
            S_CONV: if (conv_cnt == 4'd11) state_nxt = S_SEND;
            S_SEND: if (xfer && last_byte) state_nxt = (MIN_GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:  if (gap_cnt == GAP_W'(GAP_LAST)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_cnt or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            first_flag <= 1'b1;
            snap_gs    <= '0;
            snap_cf    <= '0;
            snap_lt    <= '0;
            bcd        <= '0;
            conv_bin   <= '0;
            conv_cnt   <= '0;
            byte_idx   <= '0;
            gap_cnt    <= '0;
            msg_cnt    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, like real flops.
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snap_gs  <= game_state;
                        snap_cf  <= card_find;
                        snap_lt  <= left_time;
                        bcd      <= '0;
                        conv_bin <= left_time;
                        conv_cnt <= '0;
                    end
                end
                S_CONV: begin
                    bcd      <= {bcd_adj[14:0], conv_bin[11]};
                    conv_bin <= {conv_bin[10:0], 1'b0};
                    conv_cnt <= conv_cnt + 4'd1;
                    byte_idx <= '0;
                end
                S_SEND: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 4'd1;
                        if (last_byte) begin
                            msg_cnt    <= msg_cnt + 8'd1;
                            first_flag <= 1'b0;
                            gap_cnt    <= '0;
                        end
                    end
                end
                S_GAP: gap_cnt <= gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_report_tx.sv
// Bench for game_report_tx: two instances (MIN_GAP 0 and 5) share stimulus and
// are checked against a message-level reference model.
module tb_game_report_tx;

    logic        clk_cnt = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  game_state = '0;
    logic [15:0] card_find = '0;
    logic [11:0] left_time = '0;
    logic        tx_ready;
    logic        rand_ready = 1'b0;

    logic [7:0]  tx_data_a  [2];
    logic        tx_valid_a [2];
    logic        busy_a     [2];
    logic [7:0]  msg_cnt_a  [2];

    int n_checks = 0;
    int n_fail   = 0;

    game_report_tx dut0 (
        .clk_cnt(clk_cnt), .rst_n(rst_n), .game_state(game_state), .card_find(card_find),
        .left_time(left_time), .tx_data(tx_data_a[0]), .tx_valid(tx_valid_a[0]),
        .tx_ready(tx_ready), .busy(busy_a[0]), .msg_cnt(msg_cnt_a[0])
    );

    game_report_tx #(.MIN_GAP(5)) dut5 (
        .clk_cnt(clk_cnt), .rst_n(rst_n), .game_state(game_state), .card_find(card_find),
        .left_time(left_time), .tx_data(tx_data_a[1]), .tx_valid(tx_valid_a[1]),
        .tx_ready(tx_ready), .busy(busy_a[1]), .msg_cnt(msg_cnt_a[1])
    );

    initial forever #5 clk_cnt = ~clk_cnt;

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk_cnt);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 5;
    endfunction

    function automatic logic [7:0] hx(input logic [3:0] n);
        return (n < 10) ? 8'(48 + int'(n)) : 8'(65 + int'(n) - 10);
    endfunction

    // Reference message built from plain decimal/hex arithmetic.
    function automatic logic [127:0] make_msg(input logic [1:0] gs, input logic [15:0] cf,
                                              input logic [11:0] lt);
        int t = int'(lt);
        return {8'h53, 8'(48 + int'(gs)), 8'h20, 8'h54,
                8'(48 + t / 1000), 8'(48 + (t / 100) % 10), 8'(48 + (t / 10) % 10), 8'(48 + t % 10),
                8'h20, 8'h46, hx(cf[15:12]), hx(cf[11:8]), hx(cf[7:4]), hx(cf[3:0]),
                8'h0D, 8'h0A};
    endfunction

    typedef enum logic [1:0] {M_IDLE, M_CONV, M_SEND, M_GAP} mphase_t;

    mphase_t      phase      [2];
    logic         first_m    [2];
    logic [29:0]  last_in    [2];
    logic [7:0]   mcnt       [2];
    int           rx_idx     [2];
    int           conv_cyc   [2];
    int           gap_cyc    [2];
    logic         prev_stall [2];
    logic [7:0]   prev_data  [2];
    logic [127:0] exp_vec    [2];
    logic [127:0] last_rx    [2];

    task automatic idle_step(input int d);
        check($sformatf("idle_busy%0d", d), busy_a[d], 0);
        check($sformatf("idle_valid%0d", d), tx_valid_a[d], 0);
        check($sformatf("idle_msg_cnt%0d", d), msg_cnt_a[d], mcnt[d]);
        if (first_m[d] || {game_state, card_find, left_time} != last_in[d]) begin
            exp_vec[d]  = make_msg(game_state, card_find, left_time);
            last_in[d]  = {game_state, card_find, left_time};
            phase[d]    = M_CONV;
            conv_cyc[d] = 0;
        end
    endtask

    task automatic send_step(input int d);
        check($sformatf("send_valid%0d", d), tx_valid_a[d], 1);
        check($sformatf("send_busy%0d", d), busy_a[d], 1);
        if (prev_stall[d]) check($sformatf("stall_hold%0d", d), tx_data_a[d], prev_data[d]);
        if (tx_ready) begin
            check($sformatf("byte%0d_%0d", d, rx_idx[d]), tx_data_a[d],
                  exp_vec[d][127 - 8*rx_idx[d] -: 8]);
            last_rx[d]    = {last_rx[d][119:0], tx_data_a[d]};
            rx_idx[d]     = rx_idx[d] + 1;
            prev_stall[d] = 1'b0;
            if (rx_idx[d] == 16) begin
                mcnt[d]    = mcnt[d] + 8'd1;
                first_m[d] = 1'b0;
                phase[d]   = M_GAP;
                gap_cyc[d] = 0;
            end
        end else begin
            prev_stall[d] = 1'b1;
            prev_data[d]  = tx_data_a[d];
        end
    endtask

    always @(negedge clk_cnt) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                phase[d]      = M_IDLE;
                first_m[d]    = 1'b1;
                last_in[d]    = '0;
                mcnt[d]       = '0;
                rx_idx[d]     = 0;
                prev_stall[d] = 1'b0;
                check($sformatf("rst_busy%0d", d), busy_a[d], 0);
                check($sformatf("rst_valid%0d", d), tx_valid_a[d], 0);
                check($sformatf("rst_data%0d", d), tx_data_a[d], 0);
                check($sformatf("rst_msg_cnt%0d", d), msg_cnt_a[d], 0);
            end else begin
                case (phase[d])
                    M_IDLE: idle_step(d);
                    M_CONV: begin
                        if (tx_valid_a[d]) begin
                            check($sformatf("conv_len%0d", d), conv_cyc[d], 12);
                            phase[d]      = M_SEND;
                            rx_idx[d]     = 0;
                            prev_stall[d] = 1'b0;
                            send_step(d);
                        end else begin
                            check($sformatf("conv_busy%0d", d), busy_a[d], 1);
                            conv_cyc[d]++;
                            if (conv_cyc[d] > 40) begin
                                check($sformatf("conv_timeout%0d", d), conv_cyc[d], 12);
                                phase[d] = M_IDLE;
                            end
                        end
                    end
                    M_SEND: send_step(d);
                    default: begin
                        if (busy_a[d]) begin
                            check($sformatf("gap_valid%0d", d), tx_valid_a[d], 0);
                            gap_cyc[d]++;
                            if (gap_cyc[d] > gap_of(d) + 4) begin
                                check($sformatf("gap_timeout%0d", d), gap_cyc[d], gap_of(d));
                                phase[d] = M_IDLE;
                            end
                        end else begin
                            check($sformatf("gap_len%0d", d), gap_cyc[d], gap_of(d));
                            phase[d] = M_IDLE;
                            idle_step(d);
                        end
                    end
                endcase
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_cnt);
        #1;
    endtask

    task automatic drive(input logic [1:0] gs, input logic [15:0] cf, input logic [11:0] lt);
        game_state = gs;
        card_find  = cf;
        left_time  = lt;
    endtask

    task automatic wait_idle();
        int stable = 0;
        for (int i = 0; i < 3000 && stable < 3; i++) begin
            @(posedge clk_cnt);
            if (phase[0] == M_IDLE && phase[1] == M_IDLE) stable++;
            else stable = 0;
        end
        #1;
        check("wait_idle", stable >= 3, 1);
    endtask

    task automatic wait_send();
        int i;
        for (i = 0; i < 200 && phase[0] != M_SEND; i++) @(posedge clk_cnt);
        #1;
        check("wait_send", phase[0] == M_SEND, 1);
    endtask

    initial begin
        logic [7:0] base0, base1;
        logic [127:0] lit;

        step(3);
        rst_n = 1'b1;

        // First message after reset with all-zero inputs.
        wait_idle();
        check("boot_cnt0", msg_cnt_a[0], 1);
        check("boot_cnt1", msg_cnt_a[1], 1);
        lit = {"S0 T0000 F0000", 8'h0D, 8'h0A};
        check("boot_msg", last_rx[0], lit);

        drive(2, 16'h0A3F, 12'd300);
        wait_idle();
        lit = {"S2 T0300 F0A3F", 8'h0D, 8'h0A};
        check("msg_0300", last_rx[0], lit);
        check("cnt_two", msg_cnt_a[0], 2);

        // Same message again, this time under random backpressure.
        drive(1, 16'h0A3F, 12'd300);
        wait_idle();
        rand_ready = 1'b1;
        drive(2, 16'h0A3F, 12'd300);
        wait_idle();
        rand_ready = 1'b0;
        check("stall_msg0", last_rx[0], lit);
        check("stall_msg1", last_rx[1], lit);

        // Coalescing: changes during SEND yield one follow-up with the final value.
        base0 = msg_cnt_a[0];
        base1 = msg_cnt_a[1];
        drive(3, 16'h0A3F, 12'd300);
        wait_send();
        step(3);
        left_time = 12'd299;
        step(3);
        left_time = 12'd298;
        wait_idle();
        check("coalesce_cnt0", 8'(msg_cnt_a[0] - base0), 2);
        check("coalesce_cnt1", 8'(msg_cnt_a[1] - base1), 2);
        lit = {"S3 T0298 F0A3F", 8'h0D, 8'h0A};
        check("coalesce_msg", last_rx[0], lit);

        drive(3, 16'hFFFF, 12'd4095);
        wait_idle();
        lit = {"S3 T4095 FFFFF", 8'h0D, 8'h0A};
        check("max_msg", last_rx[1], lit);

        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if ($urandom_range(0, 15) == 0)
                drive(2'($urandom_range(0, 3)), 16'($urandom), 12'($urandom_range(0, 4095)));
        end
        rand_ready = 1'b0;
        wait_idle();

        // Unchanged inputs: nothing more is sent.
        base0 = msg_cnt_a[0];
        step(40);
        check("hold_cnt", msg_cnt_a[0], base0);
        check("hold_busy", busy_a[0], 0);

        // Reset in the middle of a message.
        drive(1, 16'h1234, 12'd56);
        for (int i = 0; i < 200 && rx_idx[0] != 7; i++) @(posedge clk_cnt);
        check("mid_idx", rx_idx[0], 7);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("abort_valid%0d", d), tx_valid_a[d], 0);
            check($sformatf("abort_busy%0d", d), busy_a[d], 0);
            check($sformatf("abort_cnt%0d", d), msg_cnt_a[d], 0);
        end
        @(posedge clk_cnt);
        @(posedge clk_cnt);
        #2 rst_n = 1'b1;
        wait_idle();
        check("post_rst_cnt0", msg_cnt_a[0], 1);
        check("post_rst_cnt1", msg_cnt_a[1], 1);
        lit = {"S1 T0056 F1234", 8'h0D, 8'h0A};
        check("post_rst_msg", last_rx[0], lit);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_report_tx.md
GAME_REPORT_TX -- requirements
Module: game_report_tx

Interface
REQ-001 Parameter: MIN_GAP, default 0, number of idle clk_cnt cycles inserted after the final byte of a message before the next message may start.
REQ-002 clk_cnt  input  1  block clock; all state advances on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 game_state  input  2  game phase code: 0=WAIT, 1=SHOW, 2=GAME, 3=END.
REQ-005 card_find  input  16  found-card bitmap, bit n = card n matched.
REQ-006 left_time  input  12  remaining game time, unsigned binary, range 0-4095.
REQ-007 tx_data  output  8  ASCII byte offered to the UART transmitter.
REQ-008 tx_valid  output  1  tx_data holds a byte to send.
REQ-009 tx_ready  input  1  UART transmitter accepts tx_data this cycle.
REQ-010 busy  output  1  high from snapshot capture until the end of the gap period (REQ-021).
REQ-011 msg_cnt  output  8  count of completed messages, wraps 255->0.

Function
REQ-012 The block SHALL report game status over the byte interface as a fixed 16-byte ASCII message: 'S', state digit, ' ', 'T', 4 decimal digits, ' ', 'F', 4 hex digits, CR (0x0D), LF (0x0A).
REQ-013 State digit SHALL be 0x30 + game_state.
REQ-014 Decimal field SHALL be left_time, most significant digit first, zero-padded (e.g. 300 -> "0300", 4095 -> "4095").
REQ-015 Hex field SHALL be card_find[15:12] first, then [11:8], [7:4], [3:0], digits 0-9 -> 0x30-0x39, A-F -> uppercase 0x41-0x46.
REQ-016 FSM states: IDLE, CONV, SEND, GAP.
REQ-017 IDLE->CONV SHALL occur when the first_flag is set or when {game_state, card_find, left_time} differs from the last-sent snapshot; on that edge all three inputs SHALL be captured into the snapshot registers and busy SHALL rise.
REQ-018 CONV SHALL convert the 12-bit left_time snapshot to 4 BCD digits with a sequential shift-add-3 process taking exactly 12 cycles, then go to SEND with byte index 0.
REQ-019 SEND: tx_valid SHALL be high; a byte transfers only on a cycle where tx_valid and tx_ready are both high; the index then advances by one; tx_data SHALL stay stable while tx_valid is high and tx_ready is low.
REQ-020 Bytes SHALL be sent back-to-back, at most one byte per cycle; when tx_ready is held high, the 16 bytes go out in 16 consecutive cycles.
REQ-021 After the LF transfer, msg_cnt SHALL increment, first_flag SHALL clear and tx_valid SHALL drop; the FSM SHALL stay in GAP for MIN_GAP cycles (0 = straight to IDLE), and busy SHALL fall on entry to IDLE.
REQ-022 Input changes during CONV/SEND/GAP SHALL NOT alter the message in flight; they SHALL be reported by one later message carrying the values present at the next IDLE capture, so intermediate values are coalesced.
REQ-023 When inputs equal the snapshot and first_flag is clear, the block SHALL stay in IDLE with tx_valid low indefinitely.
REQ-024 The message SHALL be formed only from snapshot and BCD registers, never from live inputs.

Reset
REQ-025 On rst_n low, the FSM SHALL go to IDLE immediately, with tx_valid=0, tx_data=0x00, busy=0, msg_cnt=0, byte index=0, snapshot=0 and BCD=0.
REQ-026 Reset SHALL set first_flag=1, so exactly one message is sent after reset even when all inputs are zero.
REQ-027 Reset asserted mid-message SHALL abort the message with no further bytes and no msg_cnt increment; after release, a complete new message SHALL start from 'S'.

Verification
REQ-028 Release reset with inputs 0 and tx_ready=1 -> busy rises, 12 CONV cycles, then "S0 T0000 F0000\r\n" in 16 consecutive cycles, msg_cnt=1, then idle.
REQ-029 game_state=2, left_time=300, card_find=16'h0A3F -> message "S2 T0300 F0A3F\r\n".
REQ-030 tx_ready toggled pseudo-randomly during SEND -> tx_data holds while stalled; the received byte stream is identical to the REQ-029 message.
REQ-031 left_time stepped 300->299->298 during one SEND -> exactly one follow-up message with T0298; msg_cnt +2 total.
REQ-032 MIN_GAP=5 with a change pending -> exactly 5 cycles of tx_valid=0 between LF and the next capture.
REQ-033 rst_n pulsed low after byte 7 -> tx_valid drops asynchronously, msg_cnt=0; a full message follows release.
